// File: rtl/ysyx_25010008_lsu_pkg.sv
// ysyx_25010008_lsu_pkg
// Shared encodings for the load/store unit and its lane helper.
// Contents:
//   - Access size codes (SZ_B, SZ_H, SZ_W; code 3 behaves as a word).
//   - FSM state codes.
//   - AXI response codes.
//   - is_misaligned() helper, used when YSYX_LSU_ALIGN_CHECK_EN is defined.
package ysyx_25010008_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Natural alignment test; size code 3 is checked like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_lane.sv
// ysyx_25010008_lsu_lane
// Purely combinational byte-lane steering.
// Inputs:
//   off        - byte offset within the word
//   size       - access size code
//   is_unsigned - zero-extend instead of sign-extend
//   wdata_in   - right-aligned store data
//   rdata_in   - raw bus read data
// Outputs:
//   wdata_out  - store data shifted into its lanes
//   wstrb      - matching byte strobes
//   rdata_ext  - extracted and extended load data
// Lanes and strobes wrap by truncation for misaligned accesses.
module ysyx_25010008_lsu_lane
  import ysyx_25010008_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [31:0] wdata_out,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext
);

  logic [3:0]  strb_base_s;
  logic [31:0] rdata_sh_s;
  logic [4:0]  shamt_s;

  // Store lane shift, strobe generation and load extraction.
  always_comb begin
    shamt_s     = {off, 3'b000};
    wdata_out   = wdata_in << shamt_s;
    rdata_sh_s  = rdata_in >> shamt_s;
    strb_base_s = 4'b1111;
    rdata_ext   = rdata_sh_s;
    case (size)
      SZ_B: begin
        strb_base_s = 4'b0001;
        rdata_ext   = {{24{~is_unsigned & rdata_sh_s[7]}}, rdata_sh_s[7:0]};
      end
      SZ_H: begin
        strb_base_s = 4'b0011;
        rdata_ext   = {{16{~is_unsigned & rdata_sh_s[15]}}, rdata_sh_s[15:0]};
      end
      default: begin
        strb_base_s = 4'b1111;
        rdata_ext   = rdata_sh_s;
      end
    endcase
    wstrb = strb_base_s << off;
  end

endmodule

// File: rtl/ysyx_25010008_lsu.sv
// ysyx_25010008_lsu
// Load/store unit. Takes one request at a time from EXU and runs it on an
// AXI4-Lite master port. The result goes to WBU over out_valid/out_ready.
// Ports:
//   clock, reset (async, active low)
//   in_*   - EXU request (valid/ready, addr, wdata, ren, wen, size, unsigned)
//   out_*  - WBU result (valid/ready, rdata, err)
//   ar*/r* - AXI4-Lite read channels
//   aw*/w*/b* - AXI4-Lite write channels
// Optional feature YSYX_LSU_ALIGN_CHECK_EN:
//   When defined, a misaligned load or store completes with out_err=1 and
//   makes no bus access.
// All bus and result outputs come straight from flops.
module ysyx_25010008_lsu
  import ysyx_25010008_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic                bvalid
);

  logic [2:0]          state_r;
  logic                in_ready_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic                unsigned_r;
  logic                arvalid_r;
  logic                rready_r;
  logic                awvalid_r;
  logic                wvalid_r;
  logic                bready_r;
  logic                aw_done_r;
  logic                w_done_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                err_r;

  logic [1:0]          lane_off_s;
  logic [1:0]          lane_size_s;
  logic [DATA_W-1:0]   lane_wdata_s;
  logic [DATA_W/8-1:0] lane_wstrb_s;
  logic [DATA_W-1:0]   lane_rdata_s;
  logic                aw_done_s;
  logic                w_done_s;
  logic                align_err_s;

  // The lane helper sees the live request in IDLE (store steering is
  // registered at acceptance) and the registered request afterwards
  // (load extraction when R data arrives).
  always_comb begin
    if (state_r == ST_IDLE) begin
      lane_off_s  = in_addr[1:0];
      lane_size_s = in_size;
    end else begin
      lane_off_s  = addr_r[1:0];
      lane_size_s = size_r;
    end
  end

  // Write-channel completion including a handshake in the current cycle.
  always_comb begin
    aw_done_s = aw_done_r | (awvalid_r & awready);
    w_done_s  = w_done_r  | (wvalid_r & wready);
  end

  // Misalignment short-circuit; only memory operations are checked.
  always_comb begin
`ifdef YSYX_LSU_ALIGN_CHECK_EN
    align_err_s = (in_ren | in_wen) & is_misaligned(in_size, in_addr[1:0]);
`else
    align_err_s = 1'b0;
`endif
  end

  ysyx_25010008_lsu_lane u_lane (
    .off         (lane_off_s),
    .size        (lane_size_s),
    .is_unsigned (unsigned_r),
    .wdata_in    (in_wdata),
    .rdata_in    (rdata),
    .wdata_out   (lane_wdata_s),
    .wstrb       (lane_wstrb_s),
    .rdata_ext   (lane_rdata_s)
  );

  // Request FSM and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      addr_r      <= '0;
      size_r      <= SZ_B;
      unsigned_r  <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      out_valid_r <= 1'b0;
      rdata_r     <= '0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            addr_r     <= in_addr;
            size_r     <= in_size;
            unsigned_r <= in_unsigned;
            in_ready_r <= 1'b0;
            if (align_err_s) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              rdata_r     <= '0;
              err_r       <= 1'b1;
            end else if (in_ren) begin
              state_r   <= ST_RD_ADDR;
              arvalid_r <= 1'b1;
            end else if (in_wen) begin
              state_r   <= ST_WR;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              wdata_r   <= lane_wdata_s;
              wstrb_r   <= lane_wstrb_s;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              rdata_r     <= '0;
              err_r       <= 1'b0;
            end
          end
        end
        ST_RD_ADDR: begin
          if (arready) begin
            state_r   <= ST_RD_DATA;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            state_r     <= ST_DONE;
            rready_r    <= 1'b0;
            rdata_r     <= lane_rdata_s;
            err_r       <= (rresp != OKAY);
            out_valid_r <= 1'b1;
          end
        end
        ST_WR: begin
          // AW and W drop independently; move on once both have handshaken.
          if (awvalid_r && awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && wready) begin
            wvalid_r <= 1'b0;
          end
          aw_done_r <= aw_done_s;
          w_done_r  <= w_done_s;
          if (aw_done_s && w_done_s) begin
            state_r  <= ST_WR_RESP;
            bready_r <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            state_r     <= ST_DONE;
            bready_r    <= 1'b0;
            rdata_r     <= '0;
            err_r       <= (bresp != OKAY);
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_rdata = rdata_r;
  assign out_err   = err_r;
  assign araddr    = addr_r;
  assign arvalid   = arvalid_r;
  assign rready    = rready_r;
  assign awaddr    = addr_r;
  assign awvalid   = awvalid_r;
  assign wdata     = wdata_r;
  assign wstrb     = wstrb_r;
  assign wvalid    = wvalid_r;
  assign bready    = bready_r;

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// tb_ysyx_25010008_lsu
// Directed bench for ysyx_25010008_lsu. The bench plays the AXI slave and
// WBU by hand, with fixed ready/valid stall counts per vector. Expected
// values are hand-computed constants.
// Honours YSYX_LSU_ALIGN_CHECK_EN for the misaligned-load vector.
module tb_ysyx_25010008_lsu;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_ren;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bready;
  logic [1:0]  bresp;
  logic        bvalid;

  int checks_cnt;
  int fail_cnt;

  ysyx_25010008_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_ren(in_ren), .in_wen(in_wen), .in_size(in_size), .in_unsigned(in_unsigned),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic finish_result(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    check({tag, ":out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ":out_rdata"}, out_rdata, exp_rd);
    check({tag, ":out_err"}, {31'd0, out_err}, {31'd0, exp_err});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ":out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, ":in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input int ar_stall, input logic [31:0] rd,
                         input logic [1:0] rr, input logic [31:0] exp_rd, input logic exp_err,
                         input int hold);
    logic hs;
    check({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_addr = addr; in_ren = 1'b1; in_wen = 1'b0;
    in_size = size; in_unsigned = uns; in_wdata = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0; in_ren = 1'b0;
    check({tag, ":arvalid_start"}, {31'd0, arvalid}, 32'd1);
    check({tag, ":in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      arready = (c >= ar_stall);
      check({tag, ":araddr"}, araddr, addr);
      hs = arvalid && arready;
      step();
    end
    arready = 1'b0;
    check({tag, ":ar_handshake"}, {31'd0, hs}, 32'd1);
    check({tag, ":arvalid_drop"}, {31'd0, arvalid}, 32'd0);
    check({tag, ":rready"}, {31'd0, rready}, 32'd1);
    rvalid = 1'b1; rdata = rd; rresp = rr;
    step();
    rvalid = 1'b0; rdata = 32'h5A5A_5A5A; rresp = 2'd0;
    check({tag, ":rready_drop"}, {31'd0, rready}, 32'd0);
    for (int c = 0; c < hold; c++) begin
      check({tag, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ":hold_rdata"}, out_rdata, exp_rd);
      step();
    end
    finish_result(tag, exp_rd, exp_err);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input logic [31:0] exp_wd, input logic [3:0] exp_strb,
                          input int aw_stall, input int w_stall, input logic [1:0] br,
                          input logic exp_err);
    int aw_hs;
    int w_hs;
    logic aw_now;
    logic w_now;
    check({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_addr = addr; in_ren = 1'b0; in_wen = 1'b1;
    in_size = size; in_unsigned = 1'b0; in_wdata = wd;
    step();
    in_valid = 1'b0; in_wen = 1'b0;
    check({tag, ":awvalid_start"}, {31'd0, awvalid}, 32'd1);
    check({tag, ":wvalid_start"}, {31'd0, wvalid}, 32'd1);
    check({tag, ":wstrb"}, {28'd0, wstrb}, {28'd0, exp_strb});
    aw_hs = 0;
    w_hs = 0;
    for (int c = 0; c < 20 && !(aw_hs > 0 && w_hs > 0); c++) begin
      awready = (c >= aw_stall);
      wready  = (c >= w_stall);
      check({tag, ":bready_early"}, {31'd0, bready}, 32'd0);
      if (c < aw_stall) check({tag, ":awvalid_hold"}, {31'd0, awvalid}, 32'd1);
      if (c < w_stall) check({tag, ":wvalid_hold"}, {31'd0, wvalid}, 32'd1);
      if (awvalid) check({tag, ":awaddr"}, awaddr, addr);
      if (wvalid) check({tag, ":wdata"}, wdata, exp_wd);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      step();
      aw_hs += int'(aw_now);
      w_hs  += int'(w_now);
    end
    awready = 1'b0;
    wready  = 1'b0;
    check({tag, ":aw_count"}, aw_hs, 32'd1);
    check({tag, ":w_count"}, w_hs, 32'd1);
    check({tag, ":bready"}, {31'd0, bready}, 32'd1);
    check({tag, ":out_valid_early"}, {31'd0, out_valid}, 32'd0);
    bvalid = 1'b1; bresp = br;
    step();
    bvalid = 1'b0; bresp = 2'd0;
    check({tag, ":bready_drop"}, {31'd0, bready}, 32'd0);
    finish_result(tag, 32'd0, exp_err);
  endtask

  initial begin
    checks_cnt = 0; fail_cnt = 0;
    clock = 1'b0; reset = 1'b1;
    in_valid = 1'b0; in_addr = 32'd0; in_wdata = 32'd0; in_ren = 1'b0; in_wen = 1'b0;
    in_size = 2'd0; in_unsigned = 1'b0; out_ready = 1'b0;
    arready = 1'b0; rdata = 32'd0; rresp = 2'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'd0; bvalid = 1'b0;
    #1 reset = 1'b0;
    repeat (2) step();
    check("rst:in_ready", {31'd0, in_ready}, 32'd1);
    check("rst:arvalid", {31'd0, arvalid}, 32'd0);
    check("rst:awvalid", {31'd0, awvalid}, 32'd0);
    check("rst:wvalid", {31'd0, wvalid}, 32'd0);
    check("rst:out_valid", {31'd0, out_valid}, 32'd0);
    check("rst:out_err", {31'd0, out_err}, 32'd0);
    check("rst:araddr", araddr, 32'd0);
    check("rst:wdata", wdata, 32'd0);
    check("rst:wstrb", {28'd0, wstrb}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    do_load("lb_s",  32'h8000_0003, 2'd0, 1'b0, 0, 32'h80FF_FF12, 2'd0, 32'hFFFF_FF80, 1'b0, 0);
    do_load("lhu",   32'h8000_0002, 2'd1, 1'b1, 1, 32'hBEEF_1234, 2'd0, 32'h0000_BEEF, 1'b0, 0);
    do_load("lw_err",32'h8000_0000, 2'd2, 1'b0, 2, 32'h1234_5678, 2'd2, 32'h1234_5678, 1'b1, 4);
    do_load("lbu",   32'h8000_0001, 2'd0, 1'b1, 0, 32'h0000_8A00, 2'd0, 32'h0000_008A, 1'b0, 0);
    do_load("lh_s",  32'h8000_0004, 2'd1, 1'b0, 0, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0, 0);
    do_load("lsz3",  32'h8000_0008, 2'd3, 1'b0, 0, 32'hA5A5_0F0F, 2'd0, 32'hA5A5_0F0F, 1'b0, 0);

    do_store("sh",     32'h8000_0002, 2'd1, 32'h0000_ABCD, 32'hABCD_0000, 4'b1100, 3, 0, 2'd0, 1'b0);
    do_store("sb",     32'h8000_0001, 2'd0, 32'h0000_00AB, 32'h0000_AB00, 4'b0010, 0, 2, 2'd0, 1'b0);
    do_store("sw_err", 32'h8000_0010, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 0, 0, 2'd3, 1'b1);

    // Request with neither load nor store: straight to DONE with zero data.
    in_valid = 1'b1; in_addr = 32'h1234_5678; in_ren = 1'b0; in_wen = 1'b0; in_size = 2'd2;
    step();
    in_valid = 1'b0;
    check("nop:arvalid", {31'd0, arvalid}, 32'd0);
    check("nop:awvalid", {31'd0, awvalid}, 32'd0);
    finish_result("nop", 32'd0, 1'b0);

    // Misaligned word load.
`ifdef YSYX_LSU_ALIGN_CHECK_EN
    in_valid = 1'b1; in_addr = 32'h8000_0001; in_ren = 1'b1; in_wen = 1'b0; in_size = 2'd2;
    in_unsigned = 1'b0;
    step();
    in_valid = 1'b0; in_ren = 1'b0;
    check("mis:arvalid", {31'd0, arvalid}, 32'd0);
    finish_result("mis", 32'd0, 1'b1);
`else
    do_load("mis", 32'h8000_0001, 2'd2, 1'b0, 0, 32'hAABB_CCDD, 2'd0, 32'h00AA_BBCC, 1'b0, 0);
`endif

    // Asynchronous reset while waiting in RD_DATA.
    in_valid = 1'b1; in_addr = 32'h8000_0020; in_ren = 1'b1; in_wen = 1'b0; in_size = 2'd2;
    step();
    in_valid = 1'b0; in_ren = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("arst:rready_before", {31'd0, rready}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst:arvalid", {31'd0, arvalid}, 32'd0);
    check("arst:rready", {31'd0, rready}, 32'd0);
    check("arst:out_valid", {31'd0, out_valid}, 32'd0);
    check("arst:in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("arst:in_ready_after", {31'd0, in_ready}, 32'd1);
    check("arst:arvalid_after", {31'd0, arvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
